// File: rtl/uart_rx_oversampled.sv
// UART receiver: 16x-oversampled start/data/parity/stop recovery
// with a valid/ack holding register and sticky overrun.
module uart_rx_oversampled #(
    parameter int DATA_BITS         = 8,
    parameter int OVERSAMPLING_RATE = 16,
    parameter int PARITY_EN         = 1,
    parameter int PARITY_ODD        = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 BCLK,
    input  logic                 RxD,
    input  logic                 RxAck,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 RxValid,
    output logic                 ParityErr,
    output logic                 FrameErr,
    output logic                 Overrun
);

    localparam int OSW = $clog2(OVERSAMPLING_RATE);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [OSW-1:0] OS_MID   = OSW'(OVERSAMPLING_RATE / 2 - 1);
    localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLING_RATE - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic           PEN      = (PARITY_EN != 0);
    localparam logic           ODD      = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic                 rxd_m;
    logic                 rxd_s;
    logic                 bclk_d;
    logic                 tick;
    logic                 at_last;
    logic                 done;
    logic [OSW-1:0]       os_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;

    assign tick    = BCLK & ~bclk_d;
    assign at_last = tick && (os_cnt == OS_LAST);
    assign done    = (state == STOP) && at_last;

    // Idle-high line and BCLK history reset high so reset never fakes a start or a tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxd_m  <= 1'b1;
            rxd_s  <= 1'b1;
            bclk_d <= 1'b1;
        end else begin
            rxd_m  <= RxD;
            rxd_s  <= rxd_m;
            bclk_d <= BCLK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            perr      <= 1'b0;
            RxData    <= '0;
            RxValid   <= 1'b0;
            ParityErr <= 1'b0;
            FrameErr  <= 1'b0;
            Overrun   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state  <= START;
                        os_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (os_cnt == OS_MID) begin
                            os_cnt  <= '0;
                            bit_cnt <= '0;
                            state   <= rxd_s ? IDLE : DATA;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (at_last) begin
                        os_cnt <= '0;
                        shreg  <= {rxd_s, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= PEN ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (tick) begin
                        os_cnt <= os_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (at_last) begin
                        os_cnt <= '0;
                        perr   <= ((^shreg) ^ rxd_s) != ODD;
                        state  <= STOP;
                    end else if (tick) begin
                        os_cnt <= os_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (at_last) begin
                        os_cnt <= '0;
                        state  <= IDLE;
                    end else if (tick) begin
                        os_cnt <= os_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    os_cnt <= '0;
                end
            endcase

            // A completing frame wins over an ack; ack then only suppresses overrun.
            if (done) begin
                RxData    <= shreg;
                ParityErr <= PEN & perr;
                FrameErr  <= ~rxd_s;
                RxValid   <= 1'b1;
                if (RxValid && !RxAck) begin
                    Overrun <= 1'b1;
                end
            end else if (RxValid && RxAck) begin
                RxValid <= 1'b0;
                Overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: 8 data bits, even parity,
// BCLK at clk/2 so one serial bit spans 32 clk cycles.
module tb_uart_rx_oversampled;

    logic       clk;
    logic       rst_n;
    logic       BCLK;
    logic       RxD;
    logic       RxAck;
    logic [7:0] RxData;
    logic       RxValid;
    logic       ParityErr;
    logic       FrameErr;
    logic       Overrun;

    int vectors;
    int miscompares;
    int lat;

    uart_rx_oversampled #(
        .DATA_BITS(8),
        .OVERSAMPLING_RATE(16),
        .PARITY_EN(1),
        .PARITY_ODD(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .BCLK(BCLK),
        .RxD(RxD),
        .RxAck(RxAck),
        .RxData(RxData),
        .RxValid(RxValid),
        .ParityErr(ParityErr),
        .FrameErr(FrameErr),
        .Overrun(Overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BCLK edges sit 2 time units after clk negedges, away from both clk edges.
    initial begin
        BCLK = 1'b0;
        #2;
        forever #10 BCLK = ~BCLK;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        RxD   = 1'b1;
        RxAck = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_pulse();
        RxAck = 1'b1;
        @(negedge clk);
        RxAck = 1'b0;
    endtask

    // One frame, 32 clk per bit. Optional ack pulse and 1-clk reset at a
    // given cycle; lat = first cycle RxValid is seen rising (or -1).
    task automatic send(input logic [7:0] d, input logic p, input logic s,
                        input int ack_at, input int rst_at, output int l);
        logic [10:0] f;
        logic        v0;
        f = {s, p, d, 1'b0};
        l = -1;
        while (BCLK !== 1'b0) @(negedge clk);
        v0 = RxValid;
        for (int c = 0; c < 352; c++) begin
            RxD   = f[c / 32];
            RxAck = (c == ack_at);
            rst_n = (c != rst_at);
            @(negedge clk);
            if (l < 0 && !v0 && RxValid) l = c;
            if (c == rst_at) begin
                check("rst_mid_valid", RxValid, 0);
                check("rst_mid_data", RxData, 8'h00);
                check("rst_mid_perr", ParityErr, 0);
                check("rst_mid_ferr", FrameErr, 0);
                check("rst_mid_ovr", Overrun, 0);
            end
        end
        RxD   = 1'b1;
        RxAck = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        RxD         = 1'b1;
        RxAck       = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_valid", RxValid, 0);
        check("reset_data", RxData, 8'h00);
        check("reset_perr", ParityErr, 0);
        check("reset_ferr", FrameErr, 0);
        check("reset_ovr", Overrun, 0);
        rst_n = 1'b1;
        idle(40);

        // Good frame, then ack
        send(8'hA5, 1'b0, 1'b1, -1, -1, lat);
        check("a5_latency", lat, 338);
        check("a5_data", RxData, 8'hA5);
        check("a5_valid", RxValid, 1);
        check("a5_perr", ParityErr, 0);
        check("a5_ferr", FrameErr, 0);
        ack_pulse();
        check("a5_ack_valid", RxValid, 0);
        check("a5_ack_hold", RxData, 8'hA5);
        idle(20);

        // Wrong parity bit
        send(8'h3C, 1'b1, 1'b1, -1, -1, lat);
        check("3c_data", RxData, 8'h3C);
        check("3c_perr", ParityErr, 1);
        check("3c_ferr", FrameErr, 0);
        ack_pulse();
        check("3c_ack_perr_hold", ParityErr, 1);
        idle(20);

        // Stop bit low, then a clean frame
        send(8'h81, 1'b0, 1'b0, -1, -1, lat);
        check("81_data", RxData, 8'h81);
        check("81_ferr", FrameErr, 1);
        check("81_valid", RxValid, 1);
        ack_pulse();
        idle(64);
        check("81_no_spurious", RxValid, 0);
        send(8'h01, 1'b1, 1'b1, -1, -1, lat);
        check("01_data", RxData, 8'h01);
        check("01_perr", ParityErr, 0);
        check("01_ferr", FrameErr, 0);
        ack_pulse();
        idle(20);

        // Glitch of 5 ticks: false start
        while (BCLK !== 1'b0) @(negedge clk);
        RxD = 1'b0;
        repeat (10) @(negedge clk);
        RxD = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_valid", RxValid, 0);
        check("glitch_data_hold", RxData, 8'h01);
        send(8'h55, 1'b0, 1'b1, -1, -1, lat);
        check("55_data", RxData, 8'h55);
        check("55_valid", RxValid, 1);
        check("55_perr", ParityErr, 0);
        ack_pulse();
        idle(20);

        // Overrun
        send(8'h11, 1'b0, 1'b1, -1, -1, lat);
        check("11_ovr", Overrun, 0);
        send(8'h22, 1'b0, 1'b1, -1, -1, lat);
        check("22_data", RxData, 8'h22);
        check("22_ovr", Overrun, 1);
        check("22_valid", RxValid, 1);
        ack_pulse();
        check("22_ack_valid", RxValid, 0);
        check("22_ack_ovr", Overrun, 0);
        idle(20);

        // Ack coincident with completion
        send(8'h33, 1'b0, 1'b1, -1, -1, lat);
        send(8'h44, 1'b0, 1'b1, 338, -1, lat);
        check("44_data", RxData, 8'h44);
        check("44_valid", RxValid, 1);
        check("44_ovr", Overrun, 0);
        idle(20);

        // Reset in data bit 4, then a second reset mid-frame
        send(8'hF0, 1'b1, 1'b1, -1, 176, lat);
        idle(100);
        check("f0_not_delivered", RxValid, 0);
        send(8'hFE, 1'b1, 1'b1, -1, 112, lat);
        idle(400);
        check("fe_not_delivered", RxValid, 0);
        check("fe_data_clear", RxData, 8'h00);
        send(8'h0F, 1'b0, 1'b1, -1, -1, lat);
        check("0f_data", RxData, 8'h0F);
        check("0f_valid", RxValid, 1);
        check("0f_perr", ParityErr, 0);
        check("0f_ferr", FrameErr, 0);
        check("0f_ovr", Overrun, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- UART receive stage directly downstream of the baud-rate generator.
- Consumes the generator's BCLK output as a 16x-oversampling tick source.
- Recovers asynchronous serial frames from the RxD line: start bit, data bits LSB-first, optional parity, one stop bit.
- Presents each received byte to the host side through a valid/ack holding register with error flags.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8).
- OVERSAMPLING_RATE, 16, BCLK rising edges per serial bit; must be even and >= 4.
- PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.

Ports:
- clk, input, 1, system clock; BCLK is generated in this domain.
- rst_n, input, 1, reset, synchronous, active-low.
- BCLK, input, 1, baud-rate clock from the generator; used as data only, never as a clock.
- RxD, input, 1, asynchronous serial line; idles high.
- RxAck, input, 1, host consumed RxData; single-cycle pulse or held high.
- RxData, output, DATA_BITS, last received data word.
- RxValid, output, 1, RxData holds an unconsumed word.
- ParityErr, output, 1, parity mismatch on the word in RxData.
- FrameErr, output, 1, stop bit sampled low on the word in RxData.
- Overrun, output, 1, sticky: a word was overwritten before RxAck.

Behaviour:
- Reset:
  - All logic is synchronous to clk; rst_n is sampled only on the clk edge.
  - While rst_n = 0: RxData = 0, RxValid = 0, ParityErr = 0, FrameErr = 0, Overrun = 0, state = IDLE, all counters = 0.
  - The RxD synchronizer flops and the BCLK edge register reset to 1.
  - Reset mid-frame abandons the frame; no partial word is delivered.
- Input conditioning:
  - RxD passes through a 2-flop synchronizer; rxd_s is the second flop.
  - tick = BCLK & ~BCLK_d, where BCLK_d is BCLK registered on clk. tick is one clk wide per BCLK rising edge.
- Counters:
  - Oversample counter os_cnt: width clog2(OVERSAMPLING_RATE), advances only on tick.
  - Bit counter bit_cnt: counts 0..DATA_BITS-1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - rxd_s = 0 -> go to START, os_cnt = 0. No tick is required to leave IDLE.
- START:
  - On a tick with os_cnt = OVERSAMPLING_RATE/2 - 1 (mid start bit):
    - rxd_s = 0 -> go to DATA with os_cnt = 0 and bit_cnt = 0.
    - rxd_s = 1 -> false start; go to IDLE. No flags change and nothing is delivered.
  - Otherwise, on each tick, os_cnt increments.
- DATA:
  - On a tick with os_cnt = OVERSAMPLING_RATE-1: shift rxd_s into the shift register MSB side (LSB-first line order), os_cnt = 0.
  - After bit DATA_BITS-1, go to PARITY if PARITY_EN = 1, else go to STOP.
- PARITY:
  - Sample at os_cnt = OVERSAMPLING_RATE-1.
  - perr = (XOR of data bits ^ sampled bit) != PARITY_ODD.
  - Go to STOP.
- STOP:
  - Sample at os_cnt = OVERSAMPLING_RATE-1.
  - ferr = ~rxd_s.
  - Complete the frame and go to IDLE in the same cycle. Start detection rearms half a bit early.
- Frame completion (the clk cycle of the stop sample). Registered, so outputs update on the next clk edge:
  - RxData <= shift register, ParityErr <= perr (0 if PARITY_EN = 0), FrameErr <= ferr, RxValid <= 1.
  - If RxValid = 1 and RxAck = 0 in that cycle: Overrun <= 1 and the old word is overwritten.
- Handshake:
  - RxAck = 1 while RxValid = 1 and no completion in that cycle -> RxValid <= 0, Overrun <= 0.
  - RxData and the error flags hold their values after ack.
  - RxAck and completion in the same cycle -> the new word is latched, RxValid stays 1, Overrun is not set.
  - RxAck while RxValid = 0 is ignored.
- Frame errors do not block delivery; the word is still delivered with FrameErr = 1.
- Latency: RxValid rises 1 clk after the clk cycle carrying the stop-bit mid-sample tick.
- Line low at IDLE for a whole frame (break): delivers RxData = 0 with FrameErr = 1. The receiver then restarts on the still-low line.

Test Plan:
1. Defaults, BCLK from generator (Divisor = 1). Send 0xA5 with an even parity bit of 0 and stop = 1 -> RxData = 0xA5, RxValid = 1, ParityErr = 0, FrameErr = 0. Pulse RxAck -> RxValid = 0.
2. Send 0x3C with the parity bit forced to 1 -> RxData = 0x3C, ParityErr = 1, FrameErr = 0.
3. Send 0x81 with the stop bit driven 0 -> RxData = 0x81, FrameErr = 1. Then an idle line plus 0x01 -> next word received correctly.
4. Pulse RxD low for 5 ticks (less than 8), then hold high -> no RxValid, FSM back in IDLE. A following 0x55 is received.
5. Send 0x11 then 0x22 back-to-back with no ack -> RxData = 0x22, Overrun = 1. Next RxAck clears RxValid and Overrun. Repeat with RxAck asserted exactly in the completion cycle -> Overrun stays 0, RxValid stays 1.
6. Assert rst_n = 0 for 1 clk in the middle of data bit 4 of 0xF0 -> all outputs 0 on the next edge. The bench applies rst_n = 0 a second time in the middle of a later frame and checks that this second frame is not delivered. Only the subsequent 0x0F is delivered, with no errors.
